// File: rtl/wall_tracker.sv
// wall_tracker
//   Stores up to NUM_WALLS wall positions received from the wall generators.
//   For the pixel currently being drawn it reports whether the pixel lies
//   inside any stored wall. Once per frame it scans the table, one slot per
//   cycle, and reports whether the player box overlaps any wall.
//
// Ports
//   pixel_clk    sole clock, rising edge
//   reset        synchronous, active-low
//   in_valid     wall coordinate offered
//   in_x/in_y    wall top-left corner
//   in_ready     table can accept a coordinate this cycle
//   clear        one-cycle pulse, empties the table
//   hcount/vcount current pixel position
//   wall_pixel   registered: previous cycle's pixel is inside a valid wall
//   frame_start  one-cycle pulse, starts a collision scan
//   player_x/y   player box top-left corner (box is WALL_W x WALL_H)
//   hit          result of the last completed scan
//   hit_valid    one-cycle pulse when hit is updated
//   wall_count   number of valid slots
module wall_tracker #(
  parameter int NUM_WALLS = 4,
  parameter int WALL_W    = 16,
  parameter int WALL_H    = 16,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [10:0] in_x,
  input  logic [10:0] in_y,
  output logic        in_ready,
  input  logic        clear,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic        wall_pixel,
  input  logic        frame_start,
  input  logic [10:0] player_x,
  input  logic [10:0] player_y,
  output logic        hit,
  output logic        hit_valid,
  output logic [3:0]  wall_count
);

  localparam int               WPW      = $clog2(NUM_WALLS);
  localparam logic [3:0]       NW4      = 4'(NUM_WALLS);
  localparam logic [WPW-1:0]   IDX_LAST = WPW'(NUM_WALLS - 1);
  localparam logic [WPW-1:0]   ONE      = WPW'(1);
  localparam logic [11:0]      WW12     = 12'(WALL_W);
  localparam logic [11:0]      WH12     = 12'(WALL_H);
  localparam logic [10:0]      XMAX     = 11'(SCREEN_W - WALL_W);
  localparam logic [10:0]      YMAX     = 11'(SCREEN_H - WALL_H);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_e;

  state_e               state_q;
  logic [NUM_WALLS-1:0] valid_q;
  logic [10:0]          x_q [NUM_WALLS];
  logic [10:0]          y_q [NUM_WALLS];
  logic [WPW-1:0]       wp_q;
  logic [3:0]           count_q;
  logic [WPW-1:0]       idx_q;
  logic [10:0]          px_q;
  logic [10:0]          py_q;
  logic                 acc_q;
  logic                 hit_q;
  logic                 hit_valid_q;
  logic                 wall_pixel_q;
  logic                 wall_pixel_d;
  logic                 scan_hit_d;
  logic                 accept;
  logic                 store;

  // Reset gates ready so nothing is accepted while reset is held.
  assign in_ready = reset && (state_q == IDLE) && (count_q < NW4) && !clear;
  assign accept   = in_valid && in_ready;
  // Zero is the generator's "unset" value; off-screen walls are dropped too.
  assign store    = accept && (in_x != '0) && (in_y != '0)
                    && !(in_x > XMAX) && !(in_y > YMAX);

  assign wall_pixel = wall_pixel_q;
  assign hit        = hit_q;
  assign hit_valid  = hit_valid_q;
  assign wall_count = count_q;

  // Render match across all slots; bounds in 12 bits so x+WALL_W cannot wrap.
  always_comb begin
    wall_pixel_d = 1'b0;
    for (int unsigned i = 0; i < NUM_WALLS; i++) begin
      if (valid_q[i]
          && ({1'b0, hcount} >= {1'b0, x_q[i]})
          && ({1'b0, hcount} <  ({1'b0, x_q[i]} + WW12))
          && ({1'b0, vcount} >= {1'b0, y_q[i]})
          && ({1'b0, vcount} <  ({1'b0, y_q[i]} + WH12))) begin
        wall_pixel_d = 1'b1;
      end
    end
  end

  // Strict overlap test: boxes that only share an edge do not collide.
  always_comb begin
    scan_hit_d = valid_q[idx_q]
                 && ({1'b0, px_q} < ({1'b0, x_q[idx_q]} + WW12))
                 && ({1'b0, x_q[idx_q]} < ({1'b0, px_q} + WW12))
                 && ({1'b0, py_q} < ({1'b0, y_q[idx_q]} + WH12))
                 && ({1'b0, y_q[idx_q]} < ({1'b0, py_q} + WH12));
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      wp_q         <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      px_q         <= '0;
      py_q         <= '0;
      acc_q        <= 1'b0;
      hit_q        <= 1'b0;
      hit_valid_q  <= 1'b0;
      wall_pixel_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_WALLS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      wall_pixel_q <= wall_pixel_d;
      hit_valid_q  <= 1'b0;

      // Clear wins over a same-cycle write; a scan in progress then sees
      // the remaining slots as invalid.
      if (clear) begin
        valid_q <= '0;
        wp_q    <= '0;
        count_q <= '0;
      end else if (store) begin
        valid_q[wp_q] <= 1'b1;
        x_q[wp_q]     <= in_x;
        y_q[wp_q]     <= in_y;
        wp_q          <= wp_q + ONE;
        count_q       <= count_q + 4'd1;
      end

      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q <= SCAN;
            px_q    <= player_x;
            py_q    <= player_y;
            idx_q   <= '0;
            acc_q   <= 1'b0;
          end
        end
        SCAN: begin
          acc_q <= acc_q | scan_hit_d;
          idx_q <= idx_q + ONE;
          if (idx_q == IDX_LAST) begin
            state_q <= REPORT;
          end
        end
        REPORT: begin
          hit_q       <= acc_q;
          hit_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wall_tracker.md
# wall_tracker

Consumer side of the wall-coordinate generator. Accepts (x, y) wall positions over a valid/ready handshake, stores up to NUM_WALLS walls in a slot table, and for the pixel currently being drawn reports whether it lies inside any stored wall. Once per frame it also checks whether the player box overlaps any wall. It sits between the wall generators and the VGA pixel mux / game controller.

## Interface
- NUM_WALLS, 4, slot count (power of two, 2..8).
- WALL_W, 16, wall width in pixels.
- WALL_H, 16, wall height in pixels.
- SCREEN_W, 640, visible width; larger x values are rejected.
- SCREEN_H, 480, visible height; larger y values are rejected.
- pixel_clk  in  1  sole clock, all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  wall coordinate offered.
- in_x  in  11  wall left edge.
- in_y  in  11  wall top edge.
- in_ready  out  1  table can accept a coordinate this cycle.
- clear  in  1  empty the table, one-cycle pulse.
- hcount  in  11  current pixel x.
- vcount  in  11  current pixel y.
- wall_pixel  out  1  registered: (hcount, vcount) is inside a valid wall.
- frame_start  in  1  one-cycle pulse that starts a collision scan.
- player_x  in  11  player box left edge (box is WALL_W x WALL_H).
- player_y  in  11  player box top edge.
- hit  out  1  result of the last completed scan.
- hit_valid  out  1  one-cycle pulse when hit is updated.
- wall_count  out  4  number of valid slots.

## Operation
- Slot table: NUM_WALLS entries of {valid, x, y}. Write pointer wp has width log2(NUM_WALLS).
- Transfer: occurs when in_valid && in_ready.
  - If in_x == 0, in_y == 0, in_x > SCREEN_W-WALL_W, or in_y > SCREEN_H-WALL_H, the transfer is consumed and dropped. Zero is the generator's "unset" value.
  - Otherwise the coordinate is written to slot wp, the slot's valid bit is set, wp increments, and wall_count increments.
- in_ready = (state == IDLE) && (wall_count < NUM_WALLS) && !clear. When the table is full, in_ready stays 0 until clear.
- clear: zeroes all valid bits, wp and wall_count. clear takes priority over a same-cycle transfer.
- Render path:
  - Slot i matches when valid && x <= hcount < x+WALL_W && y <= vcount < y+WALL_H.
  - All bounds are computed in 12 bits so the sums cannot wrap.
  - wall_pixel is the OR across all slots, registered.
- Collision FSM states:
  - IDLE: on frame_start, go to SCAN. Capture player_x/player_y into registers and set idx=0, acc=0.
  - SCAN: one slot per cycle. acc |= valid[idx] && axis-aligned overlap of the player box with slot idx. Boxes touching at an edge do not overlap: strict <, 12-bit arithmetic. idx increments each cycle. After idx == NUM_WALLS-1, go to REPORT.
  - REPORT: hit <= acc, hit_valid=1 for one cycle, return to IDLE.
- frame_start outside IDLE is ignored.
- clear during SCAN:
  - Valid bits are zeroed immediately.
  - Slots not yet scanned count as invalid.
  - The scan still completes.

## Timing
- Reset values: in_ready=0 during reset and 1 on the first cycle after release. wall_pixel=0, hit=0, hit_valid=0, wall_count=0. All valid bits are 0, wp=0, state=IDLE.
- Reset is asserted when reset==0, sampled on the rising edge. Reset mid-scan aborts the scan to IDLE with no hit_valid pulse.
- Write latency: a coordinate accepted at edge N is visible to the render and scan logic from cycle N+1. wall_count updates at edge N.
- wall_pixel reflects the hcount/vcount sampled one cycle earlier (1-cycle latency).
- Scan latency: frame_start sampled at edge N gives hit_valid high in cycle N+NUM_WALLS+1. With NUM_WALLS=4 this is cycle N+5.
- in_ready is low from the cycle after frame_start until the cycle after REPORT.

## Test plan
- Reset then fill: release reset, offer (100,50), (200,60), (300,70), (400,80) back to back.
  - wall_count steps 1..4.
  - in_ready=0 after the 4th transfer.
  - A 5th offer of (500,90) is held, not accepted.
- Rejection:
  - Offer (0,50) -> consumed, wall_count unchanged.
  - Offer (630,50) with SCREEN_W=640, WALL_W=16 -> dropped.
  - Offer (624,50) -> accepted.
- Render: with wall (100,50), drive hcount=100..116, vcount=50.
  - wall_pixel=1 one cycle later for hcount 100..115.
  - wall_pixel=0 for hcount 116.
  - With vcount=66, wall_pixel=0 for all hcount.
- Collision, single wall (100,50):
  - player (110,60), frame_start -> hit_valid pulse 5 cycles later with hit=1.
  - player (116,50) (edge-touching) -> hit=0.
- Clear versus transfer: assert clear and in_valid with (200,60) in the same cycle -> wall_count=0, slot not written, in_ready=1 the next cycle.
- Reset mid-scan: pulse frame_start, drive reset=0 two cycles later.
  - No hit_valid pulse.
  - hit=0, state back to IDLE.
  - A subsequent scan with an empty table gives hit=0.
